// File: rtl/soc_rr_arbiter_lock.sv
// soc_rr_arbiter_lock
//   Round-robin arbiter with grant locking. One of N requesters owns the
//   shared resource until it signals done or drops its request. A rotating
//   pointer gives fairness: after a release the next scan starts just past
//   the previous owner. All outputs are registered.
//
// Optional feature (compile-time macro SOC_ARB_TIMEOUT_EN):
//   Adds a hold counter that force-releases a grant after MAX_HOLD cycles
//   and pulses `timeout` in the first cycle the grant reads 0.
//
// Parameters:
//   N         number of requesters (1..64)
//   MAX_HOLD  maximum grant length in cycles when the timeout is built (>= 2)
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   req        in   [N-1:0] level-sensitive request vector
//   done       in   current owner finishes this cycle
//   gnt        out  [N-1:0] one-hot grant
//   gnt_idx    out  [IDXW-1:0] binary owner index, qualified by gnt_valid
//   gnt_valid  out  a grant is active (== |gnt)
//   timeout    out  single-cycle pulse on forced release

package soc_rr_arbiter_lock_pkg;
  // Never returns 0 so N=1 still yields a 1-bit index/pointer.
  function automatic int unsigned clog2_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

module soc_rr_arbiter_lock
  import soc_rr_arbiter_lock_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              req,
  input  logic                      done,
  output logic [N-1:0]              gnt,
  output logic [clog2_width(N)-1:0] gnt_idx,
  output logic                      gnt_valid,
  output logic                      timeout
);

  localparam int unsigned IDXW = clog2_width(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            r_state, w_state_nx;
  logic [N-1:0]      r_gnt, w_gnt_nx;
  logic [IDXW-1:0]   r_gnt_idx, w_idx_nx;
  logic              r_gnt_valid, w_valid_nx;
  logic              r_timeout, w_timeout_nx;
  logic [IDXW-1:0]   r_ptr, w_ptr_nx;

  logic              w_pick_found;
  logic [IDXW-1:0]   w_pick_idx;
  logic [IDXW-1:0]   w_cand;
  logic [N-1:0]      w_pick_oh;
  logic              w_release;
  logic              w_to_hit;
  logic [IDXW-1:0]   w_ptr_after;

`ifdef SOC_ARB_TIMEOUT_EN
  localparam int unsigned CNTW = clog2_width(MAX_HOLD);
  logic [CNTW-1:0]   r_hold, w_hold_nx;

  assign w_to_hit = (r_hold == CNTW'(MAX_HOLD - 1));
`else
  assign w_to_hit = 1'b0;
`endif

  // First requester at or above the pointer, wrapping N-1 -> 0.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_pick_oh    = '0;
    w_cand       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IDXW'((32'(r_ptr) + k) % N);
      if (!w_pick_found && req[w_cand]) begin
        w_pick_found      = 1'b1;
        w_pick_idx        = w_cand;
        w_pick_oh[w_cand] = 1'b1;
      end
    end
  end

  // done and withdrawal together are a single release.
  assign w_release   = done || !req[r_gnt_idx];
  assign w_ptr_after = IDXW'((32'(r_gnt_idx) + 32'd1) % N);

  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_idx_nx     = r_gnt_idx;
    w_valid_nx   = r_gnt_valid;
    w_ptr_nx     = r_ptr;
    w_timeout_nx = 1'b0;
`ifdef SOC_ARB_TIMEOUT_EN
    w_hold_nx    = r_hold;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_gnt_nx   = w_pick_oh;
          w_idx_nx   = w_pick_idx;
          w_valid_nx = 1'b1;
          w_state_nx = GRANT;
`ifdef SOC_ARB_TIMEOUT_EN
          w_hold_nx  = '0;
`endif
        end
      end
      GRANT: begin
        if (w_release || w_to_hit) begin
          w_gnt_nx     = '0;
          w_valid_nx   = 1'b0;
          w_ptr_nx     = w_ptr_after;
          w_state_nx   = IDLE;
          // A normal release on the timeout edge wins; no pulse then.
          w_timeout_nx = w_to_hit && !w_release;
        end else begin
`ifdef SOC_ARB_TIMEOUT_EN
          w_hold_nx = r_hold + 1'b1;
`endif
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_ptr       <= '0;
`ifdef SOC_ARB_TIMEOUT_EN
      r_hold      <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_gnt       <= w_gnt_nx;
      r_gnt_idx   <= w_idx_nx;
      r_gnt_valid <= w_valid_nx;
      r_timeout   <= w_timeout_nx;
      r_ptr       <= w_ptr_nx;
`ifdef SOC_ARB_TIMEOUT_EN
      r_hold      <= w_hold_nx;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_soc_rr_arbiter_lock.sv
// tb_soc_rr_arbiter_lock
//   Self-checking bench for soc_rr_arbiter_lock (N=4, MAX_HOLD=16).
//   A behavioural model (owner number, pointer, hold age) predicts every
//   output each cycle; directed sequences also pin grant order, bubbles,
//   withdrawal, reset and (when SOC_ARB_TIMEOUT_EN is defined) timeout.

`timescale 1ns/1ps

module tb_soc_rr_arbiter_lock;

  localparam int N        = 4;
  localparam int MAX_HOLD = 16;
`ifdef SOC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  soc_rr_arbiter_lock #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: owner -1 means no grant.
  int m_owner = -1;
  int m_last  = 0;
  int m_ptr   = 0;
  int m_age   = 0;
  bit m_to    = 1'b0;

  // Observed DUT grant history for directed checks.
  int  dut_log[$];
  int  gap_log[$];
  int  gap_cnt;
  bit  prev_valid;
  int  age;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] q, input logic d);
    bit rel, tmo;
    if (r) begin
      m_owner = -1; m_last = 0; m_ptr = 0; m_age = 0; m_to = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && q[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          m_last  = m_owner;
          m_age   = 1;
        end
      end
    end else begin
      rel = d || !q[m_owner];
      tmo = TO_EN && (m_age == MAX_HOLD);
      if (rel || tmo) begin
        m_ptr   = (m_owner + 1) % N;
        m_to    = tmo && !rel;
        m_owner = -1;
      end else begin
        m_to = 1'b0;
        m_age++;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    check("gnt",       32'(gnt),       32'(eg));
    check("gnt_idx",   32'(gnt_idx),   32'(m_last));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("timeout",   32'(timeout),   32'(m_to));
  endtask

  // One clock: drive at negedge, step model at posedge, compare at negedge.
  task automatic cyc(input logic r, input logic [N-1:0] q, input logic d);
    rst = r; req = q; done = d;
    @(posedge clk);
    model_step(r, q, d);
    @(negedge clk);
    compare_all();
    if (gnt_valid && !prev_valid) begin
      dut_log.push_back(int'(gnt_idx));
      if (dut_log.size() > 1) gap_log.push_back(gap_cnt);
    end
    if (!gnt_valid) gap_cnt++; else gap_cnt = 0;
    age = gnt_valid ? age + 1 : 0;
    prev_valid = gnt_valid;
  endtask

  task automatic clear_logs();
    dut_log.delete(); gap_log.delete(); gap_cnt = 0; age = 0;
  endtask

  task automatic check_log(input string name, input int exp[5], input int n);
    check({name, "_count"}, 32'(dut_log.size()), 32'(n));
    for (int i = 0; i < n && i < dut_log.size(); i++)
      check($sformatf("%s_%0d", name, i), 32'(dut_log[i]), 32'(exp[i]));
  endtask

  initial begin
    int exp_seq[5];
    int hi_cnt;
    int guard;
    rst = 1'b1; req = '0; done = 1'b0; prev_valid = 1'b0;
    @(negedge clk);
    clear_logs();

    // Reset and idle.
    cyc(1, '0, 0);
    cyc(1, '0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 4'b0000, (i == 2));
    check("idle_gnt",   32'(gnt),       32'd0);
    check("idle_valid", 32'(gnt_valid), 32'd0);

    // 1010 held, done 3 cycles into each grant: 1,3,1,3 with single bubbles.
    clear_logs();
    guard = 0;
    while (dut_log.size() < 4 && guard < 100) begin
      cyc(0, 4'b1010, (age == 3));
      guard++;
    end
    while (gnt_valid && guard < 100) begin cyc(0, 4'b1010, (age == 3)); guard++; end
    exp_seq = '{1, 3, 1, 3, 0};
    check_log("alt", exp_seq, 4);
    for (int i = 0; i < gap_log.size(); i++)
      check($sformatf("alt_gap_%0d", i), 32'(gap_log[i]), 32'd1);

    // 1111 held, done on every grant: 0,1,2,3,0.
    cyc(1, '0, 0);
    clear_logs();
    guard = 0;
    while (dut_log.size() < 5 && guard < 100) begin
      cyc(0, 4'b1111, (age >= 1));
      guard++;
    end
    exp_seq = '{0, 1, 2, 3, 0};
    check_log("rr", exp_seq, 5);

    // Owner 2 withdraws with req[0] pending.
    cyc(1, '0, 0);
    cyc(0, 4'b0100, 0);
    check("wd_gnt2", 32'(gnt), 32'b0100);
    cyc(0, 4'b0101, 0);
    cyc(0, 4'b0001, 0);
    check("wd_drop_gnt", 32'(gnt),     32'd0);
    check("wd_drop_to",  32'(timeout), 32'd0);
    cyc(0, 4'b0001, 0);
    check("wd_next_gnt", 32'(gnt),     32'b0001);
    check("wd_next_idx", 32'(gnt_idx), 32'd0);

`ifdef SOC_ARB_TIMEOUT_EN
    // Hold-forever requester is cut after MAX_HOLD cycles.
    cyc(1, '0, 0);
    cyc(0, 4'b0001, 0);
    hi_cnt = 0;
    guard  = 0;
    while (gnt[0] && guard < 40) begin
      hi_cnt++;
      cyc(0, 4'b0001, 0);
      guard++;
    end
    check("to_len",   32'(hi_cnt),  32'd16);
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_gap",   32'(gnt),     32'd0);
    cyc(0, 4'b0001, 0);
    check("to_regnt", 32'(gnt),     32'b0001);
    check("to_clear", 32'(timeout), 32'd0);
`else
    hi_cnt = 0;
`endif

    // Reset mid-grant.
    cyc(1, '0, 0);
    cyc(0, 4'b0010, 0);
    cyc(0, 4'b0010, 0);
    check("rst_pre", 32'(gnt), 32'b0010);
    cyc(1, 4'b0011, 0);
    check("rst_gnt",   32'(gnt),       32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_idx",   32'(gnt_idx),   32'd0);
    check("rst_to",    32'(timeout),   32'd0);
    cyc(0, 4'b0011, 0);
    check("rst_first", 32'(gnt), 32'b0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] q;
      q = N'($urandom);
      if ($urandom_range(0, 3) == 0) q = gnt | N'($urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0 && gnt_valid) q = q | gnt;
      cyc(($urandom_range(0, 299) == 0), q, ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/soc_rr_arbiter_lock.md
# soc_rr_arbiter_lock

Round-robin arbiter with grant locking that shares one resource (e.g. a tile's NoC injection port or a shared debug/config bus) among `N` requesters. A requester, once granted, keeps the resource until it signals completion or withdraws its request. Fairness comes from a rotating priority pointer. The grant is presented both one-hot and as a binary index whose width is `clog2_width(N)` from the package functions.

## Interface
- `N`, 4: number of requesters, 1..64.
- `MAX_HOLD`, 16: maximum grant duration in cycles when the timeout is compiled in; must be ≥ 2.
- `IDXW` (localparam): `clog2_width(N)`. Width of the index outputs and the pointer.

Ports:
- `clk`, in, 1: the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, N: request vector, one bit per requester, level-sensitive.
- `done`, in, 1: the current owner finishes its transaction this cycle.
- `gnt`, out, N: one-hot grant, registered.
- `gnt_idx`, out, IDXW: binary index of the owner, registered. Valid only while `gnt_valid`=1.
- `gnt_valid`, out, 1: a grant is active. Equals |`gnt`.
- `timeout`, out, 1: single-cycle pulse when a grant is force-released.

## Operation
- State machine with two states, IDLE and GRANT. The machine also holds a pointer `ptr` (IDXW bits) that marks the highest-priority requester.
- IDLE: if `req`≠0, select the first set bit scanning from `ptr` upward, wrapping from N-1 to 0. Register `gnt`, `gnt_idx` and `gnt_valid`=1, then go to GRANT. If `req`=0, stay in IDLE.
- GRANT, release condition: `done`=1, or `req[gnt_idx]`=0 (requester withdraws), or a timeout occurs (see Configuration).
- GRANT, on release: clear `gnt`/`gnt_valid`, set `ptr` = `gnt_idx`+1 modulo N (N-1 wraps to 0), go to IDLE.
- GRANT, otherwise: the grant is held and requests from other requesters are ignored.
- `done` and withdrawal in the same cycle count as one release.
- `done` while in IDLE is ignored.
- `gnt_idx` holds its last value after release. Consumers qualify it with `gnt_valid`.
- N=1: `ptr` and `gnt_idx` are constant 0. The pointer arithmetic must not produce a 0-width vector.
- Reset values: `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0, `ptr`=0, state=IDLE, hold counter=0.
- Reset asserted mid-grant drops the grant at that clock edge.

## Timing
- Grant latency: `req` sampled high at edge t gives `gnt` high after edge t, i.e. visible in cycle t+1.
- Release: `done` sampled high at edge t makes `gnt` low in cycle t+1.
- The next grant is visible in cycle t+2. There is always exactly one idle bubble between owners.
- Owner throughput: a requester that re-requests immediately after release waits until every other pending requester has been served once.
- All outputs come straight from registers. There is no combinational path from `req` or `done` to any output.

## Configuration
- Macro: `SOC_ARB_TIMEOUT_EN`.
- When defined:
  - A hold counter of `clog2_width(MAX_HOLD)` bits clears on every grant and increments each cycle in GRANT.
  - If the counter equals MAX_HOLD-1 and neither `done` nor withdrawal is present, the grant is released on that edge and `timeout` pulses high for the cycle in which `gnt` first reads 0.
  - The maximum grant length is therefore MAX_HOLD cycles.
  - `ptr` advances exactly as for a normal release.
  - If `done` arrives on the same edge as the timeout, it is a normal release and `timeout` stays 0.
- When undefined: no counter exists, `timeout` is tied to 0, and a grant is held indefinitely.

## Test plan
- Reset, then `req`=4'b0000 for 5 cycles: `gnt`=0, `gnt_valid`=0, `gnt_idx`=0 and `timeout`=0 throughout.
- `req`=4'b1010 held, with `done` pulsed 3 cycles after each grant: grants alternate idx 1, 3, 1, 3, each with exactly one bubble cycle between them.
- `req`=4'b1111 held, `done` pulsed on every grant: order is 0, 1, 2, 3, 0. After idx 3 the pointer wraps to 0.
- Owner idx 2 drops `req[2]` mid-grant while `done`=0, with `req[0]` still high: `gnt` clears in the next cycle, idx 0 is granted one cycle later, and `timeout`=0.
- `SOC_ARB_TIMEOUT_EN`, MAX_HOLD=16, `req`=4'b0001 held, `done` never asserted: `gnt[0]` is high for exactly 16 cycles, then one cycle with `gnt`=0 and `timeout`=1, then a re-grant of idx 0.
- `rst` asserted while idx 1 is granted: all outputs are 0 in the next cycle. After release from reset with `req`=4'b0011, idx 0 is granted first.
